// File: rtl/sr_pkg.sv
// Shared definitions for the SER/SRCLK/RCLK shift-register bus.
package sr_pkg;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;
endpackage

// File: rtl/sr_receiver_if.sv
// Pin-level bus plus the receiver's frame outputs.
interface sr_receiver_if #(
  parameter int DATA_W = sr_pkg::DATA_W
);
  logic              SRCLK;
  logic              RCLK;
  logic              SER;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output SRCLK, RCLK, SER,
    input  data, data_valid, frame_err, busy
  );

  modport slave (
    input  SRCLK, RCLK, SER,
    output data, data_valid, frame_err, busy
  );
endinterface

// File: rtl/sr_sync_edge.sv
// Multi-flop synchronizer followed by one aligning flop; optional registered rising-edge output.
module sr_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;

  // lvl is the delayed copy used for edge detect; level-only users tap it too so
  // every instance has identical depth and bus alignment is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      lvl    <= sync_q[SYNC_STAGES-1];
    end
  end

  generate
    if (EDGE_EN) begin : g_edge
      always_ff @(posedge clk) begin
        if (rst) rise <= 1'b0;
        else     rise <= sync_q[SYNC_STAGES-1] & ~lvl;
      end
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/sr_receiver.sv
// Deserializing receiver: shifts SER MSB-first on SRCLK, latches a frame on RCLK.
module sr_receiver #(
  parameter int DATA_W      = sr_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  sr_receiver_if.slave   bus
);
  import sr_pkg::*;

  localparam int              CNT_W   = $clog2(DATA_W) + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic ser_s, srclk_rise, rclk_rise;
  logic srclk_lvl_unused, rclk_lvl_unused, ser_rise_unused;

  sr_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_srclk (
    .clk(clk), .rst(rst), .d(bus.SRCLK), .lvl(srclk_lvl_unused), .rise(srclk_rise));
  sr_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_rclk (
    .clk(clk), .rst(rst), .d(bus.RCLK), .lvl(rclk_lvl_unused), .rise(rclk_rise));
  sr_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_ser (
    .clk(clk), .rst(rst), .d(bus.SER), .lvl(ser_s), .rise(ser_rise_unused));

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d, err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  // Shift is resolved before the latch so a coincident SRCLK/RCLK edge counts its bit.
  always_comb begin
    sr_d    = sr_q;
    cnt_inc = cnt_q;
    state_d = state_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = err_q;
    if (srclk_rise) begin
      sr_d    = {sr_q[DATA_W-2:0], ser_s};
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      state_d = SHIFT;
    end
    cnt_d = cnt_inc;
    if (rclk_rise) begin
      data_d  = sr_d;
      dv_d    = 1'b1;
      err_d   = (cnt_inc != CNT_FULL);
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q == SHIFT);
endmodule

// File: tb/tb_sr_receiver.sv
// Table-driven and randomized bench for sr_receiver against a bit-history reference model.
module tb_sr_receiver;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_receiver_if #(.DATA_W(DW)) bus ();
  sr_receiver #(.DATA_W(DW), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  // Reference model: every bit shifted since reset, and bits since last latch.
  bit mq[$];
  int mcnt = 0;

  logic [8:0] vq[$];
  always @(negedge clk) if (!rst && bus.data_valid) vq.push_back({bus.frame_err, bus.data});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_latch(output logic [7:0] d, output logic e);
    d = '0;
    for (int i = 0; i < DW; i++)
      if (mq.size() > i) d[i] = mq[mq.size()-1-i];
    e = (mcnt != DW);
    mcnt = 0;
  endtask

  task automatic send_bit(input bit b, input int lo, input int hi);
    bus.SER = b;
    tick(lo);
    bus.SRCLK = 1'b1;
    tick(hi);
    bus.SRCLK = 1'b0;
    mq.push_back(b);
    if (mq.size() > DW) void'(mq.pop_front());
    mcnt++;
  endtask

  task automatic send_bits(input int n, input logic [63:0] bits);
    for (int i = n - 1; i >= 0; i--)
      send_bit(bits[i], $urandom_range(2, 3), $urandom_range(2, 3));
  endtask

  task automatic latch();
    bus.RCLK = 1'b1;
    tick(2);
    bus.RCLK = 1'b0;
    tick(2);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] ed, input logic ee);
    logic [8:0] v;
    int w = 0;
    while (vq.size() == 0 && w < 12) begin tick(1); w++; end
    tick(3);
    chk({tag, " nvalid"}, vq.size(), 1);
    if (vq.size() > 0) begin
      v = vq.pop_front();
      chk({tag, " data"}, v[7:0], ed);
      chk({tag, " err"}, v[8], ee);
    end
    vq.delete();
  endtask

  initial begin
    vec_t        tbl[6];
    logic [7:0]  md;
    logic        me;
    int          lat;

    tbl[0] = '{8,  16'h00A5, 8'hA5, 1'b0};
    tbl[1] = '{8,  16'h003C, 8'h3C, 1'b0};
    tbl[2] = '{8,  16'h0000, 8'h00, 1'b0};
    tbl[3] = '{5,  16'h001F, 8'h1F, 1'b1};
    tbl[4] = '{10, 16'h02CB, 8'hCB, 1'b1};
    tbl[5] = '{8,  16'h0081, 8'h81, 1'b0};

    bus.SRCLK = 1'b0; bus.RCLK = 1'b0; bus.SER = 1'b0;
    tick(5);
    chk("reset data", bus.data, 0);
    chk("reset valid", bus.data_valid, 0);
    chk("reset err", bus.frame_err, 0);
    chk("reset busy", bus.busy, 0);
    rst = 1'b0;
    tick(3);
    vq.delete();

    foreach (tbl[k]) begin
      send_bits(tbl[k].nbits, 64'(tbl[k].bits));
      tick(3);
      chk($sformatf("vec%0d busy", k), bus.busy, 1);
      latch();
      model_latch(md, me);
      check_frame($sformatf("vec%0d", k), tbl[k].exp_data, tbl[k].exp_err);
      chk($sformatf("vec%0d busy after", k), bus.busy, 0);
    end

    // Coincident 8th SRCLK and RCLK rise.
    send_bits(7, 64'h3F);
    bus.SER = 1'b0;
    tick(2);
    bus.SRCLK = 1'b1; bus.RCLK = 1'b1;
    mq.push_back(1'b0); void'(mq.pop_front()); mcnt++;
    tick(2);
    bus.SRCLK = 1'b0; bus.RCLK = 1'b0;
    tick(2);
    model_latch(md, me);
    check_frame("simul", 8'h7E, 1'b0);

    // Latch with no bits: stale data, error flagged.
    latch();
    model_latch(md, me);
    check_frame("empty", 8'h7E, 1'b1);

    // Reset mid-frame.
    send_bits(4, 64'hA);
    tick(3);
    chk("midrst busy", bus.busy, 1);
    rst = 1'b1;
    tick(1);
    chk("midrst data", bus.data, 0);
    chk("midrst valid", bus.data_valid, 0);
    chk("midrst err", bus.frame_err, 0);
    chk("midrst busy0", bus.busy, 0);
    rst = 1'b0;
    mq.delete(); mcnt = 0;
    tick(6);
    chk("midrst novalid", vq.size(), 0);
    vq.delete();
    send_bits(8, 64'h55);
    latch();
    model_latch(md, me);
    check_frame("post rst", 8'h55, 1'b0);

    // Pin RCLK rise to data_valid latency.
    send_bits(8, 64'hC3);
    tick(2);
    bus.RCLK = 1'b1;
    lat = 0;
    while (!bus.data_valid && lat < 20) begin tick(1); lat++; end
    chk("latency", lat, 4);
    bus.RCLK = 1'b0;
    model_latch(md, me);
    check_frame("lat frame", 8'hC3, 1'b0);

    // 40 edges: a wrapping counter would read 8 and hide the error.
    send_bits(40, {$urandom, $urandom});
    latch();
    model_latch(md, me);
    check_frame("sat", md, me);
    chk("sat err", me, 1);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 12);
      send_bits(n, {$urandom, $urandom});
      tick($urandom_range(0, 3));
      latch();
      model_latch(md, me);
      check_frame($sformatf("rnd%0d", r), md, me);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sr_receiver.md
# sr_receiver

Deserializing receiver for the three-wire SER/SRCLK/RCLK shift-register bus driven by the team's 8-bit serial transmitter. It oversamples the pin-level signals with the system clock and shifts SER in MSB-first on each SRCLK rising edge. On each RCLK rising edge it presents the byte with a one-cycle valid strobe. It is used for loopback checks of the transmitter and for boards where another FPGA drives the bus.

## Interface
- DATA_W, 8: bits per frame; expected SRCLK edges per RCLK.
- SYNC_STAGES, 2: synchronizer depth for each bus input; minimum 2.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- SRCLK  in  1  bus shift clock, asynchronous to clk.
- RCLK  in  1  bus latch strobe, asynchronous to clk.
- SER  in  1  bus serial data, MSB first.
- data  out  DATA_W  last latched frame.
- data_valid  out  1  one-cycle pulse when data updates.
- frame_err  out  1  registered with data_valid; high when the latched frame had a bit count other than DATA_W.
- busy  out  1  high while in SHIFT state.

## Operation
- SRCLK, RCLK and SER each pass through SYNC_STAGES flops, with equal depth so their alignment is preserved. A further flop on SRCLK and RCLK gives rising-edge detect (sync high, delayed low).
- Shift register: DATA_W bits. On an SRCLK edge it becomes {sr[DATA_W-2:0], ser_sync}, sampled the same cycle the edge is detected.
- Bit counter: width $clog2(DATA_W)+2. Increments on each SRCLK edge and saturates at its maximum value, with no wrap.
- FSM:
  - IDLE: count = 0, busy = 0. An SRCLK edge shifts, sets count to 1, and moves to SHIFT.
  - SHIFT: each SRCLK edge shifts and increments count.
  - RCLK edge in either state: data <= shift register, data_valid = 1, frame_err = (count != DATA_W), count <= 0, state <= IDLE. The shift register is not cleared; it matches 74HC595 behaviour, where stale bits remain.
- RCLK edge in IDLE with count = 0: still latches, with frame_err = 1.
- SRCLK and RCLK edges detected in the same cycle: the shift is applied first. The latched data includes the new bit, and the counted value includes it.
- More than DATA_W edges before RCLK: data holds the last DATA_W bits shifted, and frame_err = 1.
- Reset: state = IDLE; shift register, count, data, data_valid, frame_err and busy are all 0. Synchronizer and edge flops are also cleared to 0.
  - An SRCLK or RCLK line that is high at reset release produces one spurious edge. This is accepted behaviour.
  - Reset mid-frame discards the partial frame; no valid is issued.

## Timing
- Bus requirements:
  - SRCLK high and low phases are each at least 2 clk periods.
  - RCLK high is at least 2 clk periods.
  - SER is stable from SYNC_STAGES clk before each SRCLK rising edge until 1 clk after it.
- The transmitter already meets these: it changes SER at least one clk after SRCLK rises, and its SRCLK is divided from clk.
- Latency, pin RCLK rise to data_valid: SYNC_STAGES+2 clk cycles (2 sync stages, 1 edge-detect stage, 1 output register). With the default this is 4 cycles.
- data_valid is high for exactly 1 cycle per RCLK edge. data holds until the next latch.
- busy rises the cycle after the first SRCLK edge is detected. It falls together with the data_valid pulse.
- No back-pressure: a consumer must take data within one frame time.

## Structure
- Package sr_pkg holds:
  - the DATA_W default constant (8), shared with the transmitter;
  - the receiver state enum typedef (IDLE, SHIFT).
- Sub-module sr_sync_edge: an SYNC_STAGES-deep synchronizer with an optional rising-edge output and synchronous reset.
  - Two instances use the edge output (SRCLK, RCLK); one instance uses the level output only (SER).
- Top level contains the FSM, shift register, counter and output registers.

## Test plan
- Transmitter loopback: send 0xA5, then 0x3C → data_valid pulses twice with data = 0xA5 then 0x3C, and frame_err = 0 on both.
- Short frame: 5 SRCLK edges with SER = 1, then RCLK, after a prior frame of 0x00 → data = 0x1F and frame_err = 1.
- Long frame: 10 edges shifting bits 1,0,1,1,0,0,1,0,1,1, then RCLK → data = 0xCB and frame_err = 1. Then a clean 8-bit 0x81 frame → data = 0x81 and frame_err = 0.
- Simultaneous edges: the 8th SRCLK edge and the RCLK edge rise on the same clk edge, with bits 0x7E → data = 0x7E, frame_err = 0, and exactly one data_valid.
- Reset mid-frame: assert rst for 1 cycle after 4 SRCLK edges, then send a full 0x55 frame → all outputs are 0 during reset, with no valid before the 0x55 frame. The 0x55 frame gives data = 0x55 and frame_err = 0.
- Latency check: measure pin RCLK rise to data_valid → exactly 4 clk cycles with SYNC_STAGES = 2.
